wb_sequencer: RTL

- Multi-cycle controller for the write-back stage of the processor.
- Accepts one retiring-instruction descriptor at a time from execute.
- For loads, waits on the data-memory handshake.
- Drives the write-back mux select, register-bank write strobe/address and flag-register write code. Also counts retired instructions and flags memory timeouts.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_timeout_cnt.sv | 28 ++
 rtl/wb_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the write-back sequencer: descriptor classes, mux selects,
// FSM states and the flag-write "no write" code.
package wb_pkg;

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_LOAD = 2'd1;
    localparam logic [1:0] CLS_LINK = 2'd2;
    localparam logic [1:0] CLS_NOWB = 2'd3;

    localparam logic [1:0] MXRB_ALU = 2'b00;
    localparam logic [1:0] MXRB_DM  = 2'b01;
    localparam logic [1:0] MXRB_PC  = 2'b10;

    localparam logic [2:0] W_RF_NONE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2
    } wb_state_t;

    function automatic logic [1:0] mxrb_for(input logic [1:0] cls);
        case (cls)
            CLS_LOAD: return MXRB_DM;
            CLS_LINK: return MXRB_PC;
            default:  return MXRB_ALU;
        endcase
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Clearable saturating cycle counter; tc is high once the count reaches TIMEOUT-1.
module wb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc && (cnt != TC_VAL)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/wb_sequencer.sv
// Write-back stage controller: sequences ALU/LINK/LOAD/NOWB descriptors into
// register-bank writes, waits on data memory for loads and counts retirements.
module wb_sequencer
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [1:0]       ex_class,
    input  logic [4:0]       ex_rd,
    input  logic [2:0]       ex_W_RF,
    output logic             dm_req,
    input  logic             dm_ack,
    output logic [1:0]       S_MXRB,
    output logic             rb_we,
    output logic [4:0]       rb_addr,
    output logic [2:0]       W_RF,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       dbg_state
);

    // Handshake: a descriptor transfers on a rising edge where ex_valid && ex_ready;
    // ex_ready depends on state only, and the producer holds the descriptor until then.

    wb_state_t        state, state_nxt;
    logic             accept;
    logic             tc;
    logic             timeout_hit;
    logic [1:0]       mxrb_q;
    logic [4:0]       rd_q;
    logic [2:0]       wrf_q;
    logic             mem_err_q;
    logic [CNT_W-1:0] retired_q;
    logic [1:0]       ret_inc;

    function automatic wb_state_t next_for_class(input logic [1:0] cls);
        case (cls)
            CLS_LOAD: return ST_WAIT_MEM;
            CLS_NOWB: return ST_IDLE;
            default:  return ST_WRITE;
        endcase
    endfunction

    assign ex_ready = (state == ST_IDLE) || (state == ST_WRITE);
    assign accept   = ex_valid && ex_ready;

    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (accept && (ex_class == CLS_LOAD)),
        .inc   ((state == ST_WAIT_MEM) && !dm_ack),
        .tc    (tc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dm_req      = 1'b0;
        rb_we       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = next_for_class(ex_class);
            end
            ST_WAIT_MEM: begin
                dm_req = 1'b1;
                if (dm_ack) begin
                    state_nxt = ST_WRITE;
                end else if (tc) begin
                    state_nxt   = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_WRITE: begin
                rb_we     = 1'b1;
                state_nxt = accept ? next_for_class(ex_class) : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOWB leaves the mux select and address untouched so the datapath stays quiet.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mxrb_q <= MXRB_ALU;
            rd_q   <= 5'd0;
            wrf_q  <= W_RF_NONE;
        end else if (accept && (ex_class != CLS_NOWB)) begin
            mxrb_q <= mxrb_for(ex_class);
            rd_q   <= ex_rd;
            wrf_q  <= (ex_class == CLS_ALU) ? ex_W_RF : W_RF_NONE;
        end
    end

    // A WRITE and a NOWB accept in the same cycle retire two descriptors.
    assign ret_inc = {1'b0, (state == ST_WRITE)} + {1'b0, (accept && (ex_class == CLS_NOWB))};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            retired_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            retired_q <= retired_q + CNT_W'(ret_inc);
            mem_err_q <= timeout_hit;
        end
    end

    assign S_MXRB    = mxrb_q;
    assign rb_addr   = rd_q;
    assign W_RF      = rb_we ? wrf_q : W_RF_NONE;
    assign mem_err   = mem_err_q;
    assign retired   = retired_q;
    assign dbg_state = state;

endmodule
